pwm_capture: RTL and testbench

PWM_CAPTURE -- requirements
Module: pwm_capture

---
 rtl/pwm_capture.sv | 216 +++++++++++++++++++++
 tb/tb_pwm_capture.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM duty/period capture with stuck-input detection
//
// Measures the high time and full period of an asynchronous PWM input and
// flags an input that stops toggling.
//
// Ports:
//   clk          - single system clock
//   rst          - asynchronous active-high reset
//   pwm_in       - PWM waveform, asynchronous to clk
//   duty_value   - measured high time in cycles, clamped to PWM_INTERVAL-1
//   period_value - measured period in cycles, clamped to TIMEOUT
//   valid        - one-cycle pulse when duty_value/period_value update
//   stuck_high   - input held high for TIMEOUT cycles
//   stuck_low    - input held low for TIMEOUT cycles
`timescale 1ns/1ps

module pwm_capture #(
    parameter int PWM_INTERVAL = 1200,
    parameter int TIMEOUT      = 2400
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             pwm_in,
    output logic [$clog2(PWM_INTERVAL)-1:0]  duty_value,
    output logic [$clog2(TIMEOUT+1)-1:0]     period_value,
    output logic                             valid,
    output logic                             stuck_high,
    output logic                             stuck_low
);

    localparam int DW = $clog2(PWM_INTERVAL);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
    localparam logic [DW-1:0] DUTY_MAX = DW'(PWM_INTERVAL - 1);

    typedef enum logic [1:0] {
        WAIT_RISE,
        MEAS_HIGH,
        MEAS_LOW,
        STUCK
    } state_t;

    state_t          state_q, state_d;
    logic            sync_meta_q, sync_meta_d;
    logic            s_q, s_d;
    logic            s_prev_q, s_prev_d;
    logic [1:0]      fill_q, fill_d;
    logic [CW-1:0]   high_q, high_d;
    logic [CW-1:0]   low_q, low_d;
    logic [DW-1:0]   duty_q, duty_d;
    logic [CW-1:0]   period_q, period_d;
    logic            valid_q, valid_d;
    logic            stuck_high_q, stuck_high_d;
    logic            stuck_low_q, stuck_low_d;

    logic            edge_ok;
    logic            rise;
    logic            fall;
    logic [CW-1:0]   high_inc;
    logic [CW-1:0]   low_inc;
    logic [CW:0]     period_sum;
    logic [CW-1:0]   period_pub;
    logic [DW-1:0]   duty_pub;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
        return (v >= CNT_MAX) ? CNT_MAX : v + CW'(1);
    endfunction

    // The synchronizer and s_prev come out of reset at 0. If pwm_in is high
    // at release, the pipeline filling up would look like a rise and start a
    // period whose true start is unknown. Edges are only trusted once all
    // three stages hold real samples.
    assign edge_ok = (fill_q == 2'd3);
    assign rise    = edge_ok &  s_q & ~s_prev_q;
    assign fall    = edge_ok & ~s_q &  s_prev_q;

    assign high_inc   = sat_inc(high_q);
    assign low_inc    = sat_inc(low_q);
    assign period_sum = {1'b0, high_q} + {1'b0, low_q};
    assign period_pub = (period_sum > (CW+1)'(TIMEOUT)) ? CNT_MAX : period_sum[CW-1:0];
    assign duty_pub   = (high_q >= CW'(PWM_INTERVAL - 1)) ? DUTY_MAX : high_q[DW-1:0];

    always_comb begin
        sync_meta_d  = pwm_in;
        s_d          = sync_meta_q;
        s_prev_d     = s_q;
        fill_d       = edge_ok ? fill_q : fill_q + 2'd1;
        state_d      = state_q;
        high_d       = high_q;
        low_d        = low_q;
        duty_d       = duty_q;
        period_d     = period_q;
        valid_d      = 1'b0;
        stuck_high_d = stuck_high_q;
        stuck_low_d  = stuck_low_q;

        case (state_q)
            WAIT_RISE: begin
                if (rise) begin
                    state_d = MEAS_HIGH;
                    high_d  = CW'(1);
                    low_d   = '0;
                end else if (!s_q) begin
                    // Only a low run can time out here: a high level seen
                    // without a rise just restarts the run counter.
                    low_d = low_inc;
                    if (low_inc == CNT_MAX) begin
                        state_d     = STUCK;
                        stuck_low_d = 1'b1;
                        duty_d      = '0;
                        period_d    = '0;
                        valid_d     = 1'b1;
                    end
                end else begin
                    low_d = '0;
                end
            end

            MEAS_HIGH: begin
                if (fall) begin
                    state_d = MEAS_LOW;
                    low_d   = CW'(1);
                end else begin
                    high_d = high_inc;
                    if (high_inc == CNT_MAX) begin
                        state_d      = STUCK;
                        stuck_high_d = 1'b1;
                        duty_d       = DUTY_MAX;
                        period_d     = '0;
                        valid_d      = 1'b1;
                    end
                end
            end

            MEAS_LOW: begin
                if (rise) begin
                    // Rise closes the period and opens the next one.
                    state_d  = MEAS_HIGH;
                    duty_d   = duty_pub;
                    period_d = period_pub;
                    valid_d  = 1'b1;
                    high_d   = CW'(1);
                    low_d    = '0;
                end else begin
                    low_d = low_inc;
                    if (low_inc == CNT_MAX) begin
                        state_d     = STUCK;
                        stuck_low_d = 1'b1;
                        duty_d      = '0;
                        period_d    = '0;
                        valid_d     = 1'b1;
                    end
                end
            end

            STUCK: begin
                // Any edge here is necessarily toward the opposite level.
                if (rise) begin
                    state_d      = MEAS_HIGH;
                    stuck_high_d = 1'b0;
                    stuck_low_d  = 1'b0;
                    high_d       = CW'(1);
                    low_d        = '0;
                end else if (fall) begin
                    state_d      = WAIT_RISE;
                    stuck_high_d = 1'b0;
                    stuck_low_d  = 1'b0;
                    high_d       = '0;
                    low_d        = CW'(1);
                end
            end

            default: begin
                state_d = WAIT_RISE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= WAIT_RISE;
            sync_meta_q  <= 1'b0;
            s_q          <= 1'b0;
            s_prev_q     <= 1'b0;
            fill_q       <= 2'd0;
            high_q       <= '0;
            low_q        <= '0;
            duty_q       <= '0;
            period_q     <= '0;
            valid_q      <= 1'b0;
            stuck_high_q <= 1'b0;
            stuck_low_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_meta_q  <= sync_meta_d;
            s_q          <= s_d;
            s_prev_q     <= s_prev_d;
            fill_q       <= fill_d;
            high_q       <= high_d;
            low_q        <= low_d;
            duty_q       <= duty_d;
            period_q     <= period_d;
            valid_q      <= valid_d;
            stuck_high_q <= stuck_high_d;
            stuck_low_q  <= stuck_low_d;
        end
    end

    assign duty_value   = duty_q;
    assign period_value = period_q;
    assign valid        = valid_q;
    assign stuck_high   = stuck_high_q;
    assign stuck_low    = stuck_low_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
`timescale 1ns/1ps

module tb_pwm_capture;

    localparam int PI = 1200;
    localparam int TO = 2400;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in = 1'b0;
    logic [10:0] duty_value;
    logic [11:0] period_value;
    logic        valid;
    logic        stuck_high;
    logic        stuck_low;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int rel_cyc  = 0;

    int ev_cyc[$];
    int ev_duty[$];
    int ev_period[$];
    bit ev_sh[$];
    bit ev_sl[$];
    int rise_cyc[$];
    int q_h[$];
    int q_l[$];

    int bad_both   = 0;
    int bad_consec = 0;
    bit prev_valid = 1'b0;

    pwm_capture #(.PWM_INTERVAL(PI), .TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .pwm_in       (pwm_in),
        .duty_value   (duty_value),
        .period_value (period_value),
        .valid        (valid),
        .stuck_high   (stuck_high),
        .stuck_low    (stuck_low)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            prev_valid = 1'b0;
        end else begin
            if (valid) begin
                ev_cyc.push_back(cyc);
                ev_duty.push_back(int'(duty_value));
                ev_period.push_back(int'(period_value));
                ev_sh.push_back(stuck_high);
                ev_sl.push_back(stuck_low);
            end
            if (stuck_high && stuck_low) bad_both++;
            if (valid && prev_valid) bad_consec++;
            prev_valid = valid;
        end
    end

    function automatic int clamp(input int v, input int hi);
        return (v > hi) ? hi : v;
    endfunction

    task automatic clear_log();
        ev_cyc.delete();
        ev_duty.delete();
        ev_period.delete();
        ev_sh.delete();
        ev_sl.delete();
        rise_cyc.delete();
    endtask

    // Hold pwm_in at lvl for exactly n clock cycles; returns #1 after an edge.
    task automatic drive(input logic lvl, input int n);
        if (lvl && !pwm_in) rise_cyc.push_back(cyc);
        pwm_in = lvl;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic lvl);
        @(posedge clk);
        #1;
        pwm_in = lvl;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        rel_cyc = cyc;
        clear_log();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pwm_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (duty_value !== 11'd0) begin failures++; $display("FAIL reset_duty: got %0d expected 0", duty_value); end
        checks++; if (period_value !== 12'd0) begin failures++; $display("FAIL reset_period: got %0d expected 0", period_value); end
        checks++; if (valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %0b expected 0", valid); end
        checks++; if (stuck_high !== 1'b0) begin failures++; $display("FAIL reset_stuck_high: got %0b expected 0", stuck_high); end
        checks++; if (stuck_low !== 1'b0) begin failures++; $display("FAIL reset_stuck_low: got %0b expected 0", stuck_low); end
        rst = 1'b0;
    endtask

    // Plays q_h/q_l as consecutive full periods, closes the last one with a
    // final rise, and compares the published stream with the model: one
    // publish per full period, three cycles after the rise that closes it.
    task automatic test_periods(input string name);
        int n;
        int m;
        do_reset(1'b0);
        drive(1'b0, 20);
        n = q_h.size();
        for (int i = 0; i < n; i++) begin
            drive(1'b1, q_h[i]);
            drive(1'b0, q_l[i]);
        end
        drive(1'b1, 20);
        drive(1'b0, 20);
        checks++;
        if (ev_cyc.size() != n) begin
            failures++;
            $display("FAIL %s_count: got %0d publishes expected %0d", name, ev_cyc.size(), n);
        end
        m = (ev_cyc.size() < n) ? ev_cyc.size() : n;
        for (int i = 0; i < m; i++) begin
            checks++;
            if (ev_duty[i] != clamp(q_h[i], PI - 1)) begin
                failures++;
                $display("FAIL %s_duty[%0d]: got %0d expected %0d", name, i, ev_duty[i], clamp(q_h[i], PI - 1));
            end
            checks++;
            if (ev_period[i] != clamp(q_h[i] + q_l[i], TO)) begin
                failures++;
                $display("FAIL %s_period[%0d]: got %0d expected %0d", name, i, ev_period[i], clamp(q_h[i] + q_l[i], TO));
            end
            checks++;
            if (ev_cyc[i] != rise_cyc[i + 1] + 3) begin
                failures++;
                $display("FAIL %s_time[%0d]: got cycle %0d expected %0d", name, i, ev_cyc[i], rise_cyc[i + 1] + 3);
            end
        end
    endtask

    task automatic test_nominal();
        q_h.delete(); q_l.delete();
        repeat (4) begin q_h.push_back(300); q_l.push_back(900); end
        test_periods("nominal");
    endtask

    task automatic test_saturate();
        q_h.delete(); q_l.delete();
        repeat (3) begin q_h.push_back(1500); q_l.push_back(500); end
        test_periods("saturate");
    endtask

    task automatic test_min_pulse();
        q_h.delete(); q_l.delete();
        repeat (3) begin q_h.push_back(1); q_l.push_back(1199); end
        repeat (2) begin q_h.push_back(1199); q_l.push_back(1); end
        test_periods("min_pulse");
    endtask

    task automatic test_random();
        q_h.delete(); q_l.delete();
        repeat (6) begin
            q_h.push_back(int'($urandom_range(1, 1500)));
            q_l.push_back(int'($urandom_range(1, 1500)));
        end
        test_periods("random");
    endtask

    task automatic test_stuck_high();
        int n_ev;
        do_reset(1'b0);
        drive(1'b0, 20);
        repeat (2) begin drive(1'b1, 300); drive(1'b0, 900); end
        drive(1'b1, 2450);
        checks++;
        if (ev_cyc.size() != 3) begin
            failures++;
            $display("FAIL stuck_high_count: got %0d publishes expected 3", ev_cyc.size());
        end else begin
            checks++; if (ev_duty[0] != 300 || ev_period[0] != 1200) begin failures++; $display("FAIL stuck_high_pre: got %0d/%0d expected 300/1200", ev_duty[0], ev_period[0]); end
            checks++; if (ev_duty[2] != PI - 1) begin failures++; $display("FAIL stuck_high_duty: got %0d expected %0d", ev_duty[2], PI - 1); end
            checks++; if (ev_period[2] != 0) begin failures++; $display("FAIL stuck_high_period: got %0d expected 0", ev_period[2]); end
            checks++; if (ev_sh[2] != 1'b1 || ev_sl[2] != 1'b0) begin failures++; $display("FAIL stuck_high_flags: got sh=%0b sl=%0b expected sh=1 sl=0", ev_sh[2], ev_sl[2]); end
            checks++; if (ev_cyc[2] != rise_cyc[2] + 2 + TO) begin failures++; $display("FAIL stuck_high_time: got cycle %0d expected %0d", ev_cyc[2], rise_cyc[2] + 2 + TO); end
        end
        checks++; if (stuck_high !== 1'b1) begin failures++; $display("FAIL stuck_high_level: got %0b expected 1", stuck_high); end
        n_ev = ev_cyc.size();
        drive(1'b0, 10);
        checks++; if (stuck_high !== 1'b0) begin failures++; $display("FAIL stuck_high_clear: got %0b expected 0", stuck_high); end
        checks++; if (ev_cyc.size() != n_ev) begin failures++; $display("FAIL stuck_high_exit_valid: got %0d publishes expected %0d", ev_cyc.size(), n_ev); end
    endtask

    task automatic test_stuck_low();
        do_reset(1'b0);
        drive(1'b0, 2450);
        checks++;
        if (ev_cyc.size() != 1) begin
            failures++;
            $display("FAIL stuck_low_count: got %0d publishes expected 1", ev_cyc.size());
        end else begin
            checks++; if (ev_cyc[0] != rel_cyc + TO) begin failures++; $display("FAIL stuck_low_time: got cycle %0d expected %0d", ev_cyc[0], rel_cyc + TO); end
            checks++; if (ev_duty[0] != 0 || ev_period[0] != 0) begin failures++; $display("FAIL stuck_low_values: got %0d/%0d expected 0/0", ev_duty[0], ev_period[0]); end
            checks++; if (ev_sl[0] != 1'b1 || ev_sh[0] != 1'b0) begin failures++; $display("FAIL stuck_low_flags: got sh=%0b sl=%0b expected sh=0 sl=1", ev_sh[0], ev_sl[0]); end
        end
        checks++; if (stuck_low !== 1'b1) begin failures++; $display("FAIL stuck_low_level: got %0b expected 1", stuck_low); end
        drive(1'b1, 10);
        checks++; if (stuck_low !== 1'b0) begin failures++; $display("FAIL stuck_low_clear: got %0b expected 0", stuck_low); end
        checks++; if (ev_cyc.size() != 1) begin failures++; $display("FAIL stuck_low_exit_valid: got %0d publishes expected 1", ev_cyc.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset(1'b0);
        drive(1'b0, 20);
        drive(1'b1, 600);
        drive(1'b0, 600);
        drive(1'b1, 100);
        checks++; if (duty_value !== 11'd600) begin failures++; $display("FAIL reset_mid_pre_duty: got %0d expected 600", duty_value); end
        rst = 1'b1;
        #1;
        checks++; if (duty_value !== 11'd0 || period_value !== 12'd0) begin failures++; $display("FAIL reset_mid_async: got %0d/%0d expected 0/0", duty_value, period_value); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (valid !== 1'b0 || stuck_high !== 1'b0 || stuck_low !== 1'b0) begin failures++; $display("FAIL reset_mid_flags: got v=%0b sh=%0b sl=%0b expected 0", valid, stuck_high, stuck_low); end
        rst = 1'b0;
        clear_log();
        drive(1'b1, 400);
        drive(1'b0, 600);
        drive(1'b1, 600);
        drive(1'b0, 600);
        drive(1'b1, 20);
        drive(1'b0, 20);
        checks++;
        if (ev_cyc.size() != 1) begin
            failures++;
            $display("FAIL reset_mid_count: got %0d publishes expected 1", ev_cyc.size());
        end else begin
            checks++; if (ev_duty[0] != 600 || ev_period[0] != 1200) begin failures++; $display("FAIL reset_mid_values: got %0d/%0d expected 600/1200", ev_duty[0], ev_period[0]); end
            checks++; if (ev_cyc[0] != rise_cyc[1] + 3) begin failures++; $display("FAIL reset_mid_time: got cycle %0d expected %0d", ev_cyc[0], rise_cyc[1] + 3); end
        end
    endtask

    task automatic test_invariants();
        checks++; if (bad_both != 0) begin failures++; $display("FAIL both_stuck: got %0d cycles expected 0", bad_both); end
        checks++; if (bad_consec != 0) begin failures++; $display("FAIL consecutive_valid: got %0d cycles expected 0", bad_consec); end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_stuck_high();
        test_saturate();
        test_reset_mid();
        test_stuck_low();
        test_min_pulse();
        test_random();
        test_invariants();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
